// File: rtl/lp_four_to_six.sv
// 4-to-6 sample gearbox: packs three 4-lane beats into two 6-lane words, oldest sample in lane 0.
// Optional sticky misalignment flag enabled with `define LP_FOUR_TO_SIX_SYNCERR_EN.
module lp_four_to_six #(
  parameter int NBITS = 12
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               ce_i,
  input  logic               sync_i,
  input  logic [4*NBITS-1:0] dat_i,
  output logic [6*NBITS-1:0] dat_o,
  output logic               valid_o,
  output logic               sync_err_o
);

  typedef enum logic [1:0] {
    PH0 = 2'd0,
    PH1 = 2'd1,
    PH2 = 2'd2
  } phase_t;

  phase_t             phase_q;
  phase_t             phase_d;
  phase_t             eff_phase;
  logic [4*NBITS-1:0] store_q;
  logic [4*NBITS-1:0] store_d;
  logic [6*NBITS-1:0] dat_p0;
  logic               vld_p0;

  // A qualified sync restarts the frame, discarding whatever is half-assembled.
  always_comb begin
    eff_phase = (ce_i && sync_i) ? PH0 : phase_q;
    phase_d   = phase_q;
    store_d   = store_q;
    dat_p0    = dat_o;
    vld_p0    = 1'b0;
    if (ce_i) begin
      unique case (eff_phase)
        PH0: begin
          store_d = dat_i;
          phase_d = PH1;
        end
        PH1: begin
          dat_p0                  = {dat_i[0 +: 2*NBITS], store_q};
          store_d[0 +: 2*NBITS]   = dat_i[2*NBITS +: 2*NBITS];
          vld_p0                  = 1'b1;
          phase_d                 = PH2;
        end
        PH2: begin
          dat_p0  = {dat_i, store_q[0 +: 2*NBITS]};
          vld_p0  = 1'b1;
          phase_d = PH0;
        end
        default: begin
          phase_d = PH0;
        end
      endcase
    end
  end

  // Output register stage: dat_o holds between words, only valid_o pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q <= PH0;
      store_q <= '0;
      dat_o   <= '0;
      valid_o <= 1'b0;
    end else begin
      phase_q <= phase_d;
      store_q <= store_d;
      dat_o   <= dat_p0;
      valid_o <= vld_p0;
    end
  end

`ifdef LP_FOUR_TO_SIX_SYNCERR_EN
  // Sticky: any sync landing mid-frame means the source lost alignment at some point.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_err_o <= 1'b0;
    end else if (ce_i && sync_i && (phase_q != PH0)) begin
      sync_err_o <= 1'b1;
    end
  end
`else
  assign sync_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_lp_four_to_six.sv
// Directed table-driven bench for lp_four_to_six (NBITS=12), plus a long stream with stalls.
module tb_lp_four_to_six;

  localparam int NBITS = 12;
  localparam int IW    = 4 * NBITS;
  localparam int OW    = 6 * NBITS;
`ifdef LP_FOUR_TO_SIX_SYNCERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_i;
  logic          ce_i;
  logic          sync_i;
  logic [IW-1:0] dat_i;
  logic [OW-1:0] dat_o;
  logic          valid_o;
  logic          sync_err_o;

  int checks   = 0;
  int failures = 0;

  lp_four_to_six #(.NBITS(NBITS)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .ce_i       (ce_i),
    .sync_i     (sync_i),
    .dat_i      (dat_i),
    .dat_o      (dat_o),
    .valid_o    (valid_o),
    .sync_err_o (sync_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          ce;
    logic          sync;
    logic [IW-1:0] din;
    logic          ev;
    logic [OW-1:0] ed;
    logic          ee;
    string         name;
  } vec_t;

  vec_t vq[$];

  localparam logic [IW-1:0] JUNK = 48'hA5A_5A5_C3C_3C3;

  // Beat whose lane i carries sample value b+i.
  function automatic logic [IW-1:0] beat(input int b);
    logic [IW-1:0] r;
    for (int i = 0; i < 4; i++) r[i*NBITS +: NBITS] = NBITS'(b + i);
    return r;
  endfunction

  function automatic logic [OW-1:0] word(input int b);
    logic [OW-1:0] r;
    for (int i = 0; i < 6; i++) r[i*NBITS +: NBITS] = NBITS'(b + i);
    return r;
  endfunction

  function automatic void add(input logic rst, input logic ce, input logic sync,
                              input logic [IW-1:0] din, input logic ev,
                              input logic [OW-1:0] ed, input logic ee, input string name);
    vec_t v;
    v.rst = rst; v.ce = ce; v.sync = sync; v.din = din;
    v.ev = ev; v.ed = ed; v.ee = ee; v.name = name;
    vq.push_back(v);
  endfunction

  task automatic check1(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_and_check(input vec_t v);
    rst_i = v.rst; ce_i = v.ce; sync_i = v.sync; dat_i = v.din;
    @(posedge clk);
    #1;
    check1({v.name, ".valid"}, OW'(valid_o), OW'(v.ev));
    check1({v.name, ".dat"}, dat_o, v.ed);
    check1({v.name, ".err"}, OW'(sync_err_o), OW'(v.ee));
  endtask

  initial begin
    rst_i = 1'b1; ce_i = 1'b0; sync_i = 1'b0; dat_i = '0;

    // Reset overrides a concurrent sync beat.
    add(1, 1, 1, beat(40), 0, '0, 0, "rst");
    // Continuous stream.
    add(0, 1, 0, beat(0),  0, '0,        0, "cont0");
    add(0, 1, 0, beat(4),  1, word(0),   0, "cont1");
    add(0, 1, 0, beat(8),  1, word(6),   0, "cont2");
    add(0, 1, 0, beat(12), 0, word(6),   0, "cont3");
    add(0, 1, 0, beat(16), 1, word(12),  0, "cont4");
    add(0, 1, 0, beat(20), 1, word(18),  0, "cont5");
    // Stalls of 1 and 5 cycles between beats; dat_o holds.
    add(1, 0, 0, '0,       0, '0,        0, "st_rst");
    add(0, 1, 0, beat(0),  0, '0,        0, "st0");
    add(0, 0, 0, JUNK,     0, '0,        0, "st0s");
    add(0, 1, 0, beat(4),  1, word(0),   0, "st1");
    for (int i = 0; i < 5; i++) add(0, 0, 0, JUNK, 0, word(0), 0, "st1s");
    add(0, 1, 0, beat(8),  1, word(6),   0, "st2");
    add(0, 0, 0, JUNK,     0, word(6),   0, "st2s");
    add(0, 1, 0, beat(12), 0, word(6),   0, "st3");
    for (int i = 0; i < 5; i++) add(0, 0, 0, JUNK, 0, word(6), 0, "st3s");
    add(0, 1, 0, beat(16), 1, word(12),  0, "st4");
    // Resync mid-frame drops samples 6,7.
    add(1, 0, 0, '0,        0, '0,        0, "rs_rst");
    add(0, 1, 0, beat(0),   0, '0,        0, "rs0");
    add(0, 1, 0, beat(4),   1, word(0),   0, "rs1");
    add(0, 1, 1, beat(100), 0, word(0),   ERR_ON, "rs_sync");
    add(0, 1, 0, beat(104), 1, word(100), ERR_ON, "rs2");
    add(0, 1, 0, beat(108), 1, word(106), ERR_ON, "rs3");
    add(0, 0, 0, JUNK,      0, word(106), ERR_ON, "rs_sticky");
    // Reset mid-frame after words were produced.
    add(1, 0, 0, '0,       0, '0,        0, "rm_rst0");
    add(0, 1, 0, beat(0),  0, '0,        0, "rm0");
    add(0, 1, 0, beat(4),  1, word(0),   0, "rm1");
    add(0, 1, 0, beat(8),  1, word(6),   0, "rm2");
    add(0, 1, 0, beat(12), 0, word(6),   0, "rm3");
    add(1, 0, 0, JUNK,     0, '0,        0, "rm_rst1");
    add(0, 1, 0, beat(20), 0, '0,        0, "rm4");
    add(0, 1, 0, beat(24), 1, word(20),  0, "rm5");
    // Idle sync in phase 1 is ignored.
    add(1, 0, 0, '0,       0, '0,        0, "id_rst");
    add(0, 1, 0, beat(0),  0, '0,        0, "id0");
    add(0, 0, 1, JUNK,     0, '0,        0, "id_sync");
    add(0, 1, 0, beat(4),  1, word(0),   0, "id1");
    add(0, 1, 0, beat(8),  1, word(6),   0, "id2");
    // Aligned sync on every third beat matches the continuous stream.
    add(1, 0, 0, '0,       0, '0,        0, "al_rst");
    add(0, 1, 1, beat(0),  0, '0,        0, "al0");
    add(0, 1, 0, beat(4),  1, word(0),   0, "al1");
    add(0, 1, 0, beat(8),  1, word(6),   0, "al2");
    add(0, 1, 1, beat(12), 0, word(6),   0, "al3");
    add(0, 1, 0, beat(16), 1, word(12),  0, "al4");
    add(0, 1, 0, beat(20), 1, word(18),  0, "al5");
    add(0, 1, 1, beat(24), 0, word(18),  0, "al6");

    @(negedge clk);
    foreach (vq[i]) drive_and_check(vq[i]);

    // Long stream with pseudo-random stalls: group g of three beats yields words 12g and 12g+6.
    begin
      vec_t v;
      logic [OW-1:0] held;
      v.rst = 1; v.ce = 0; v.sync = 0; v.din = '0; v.ev = 0; v.ed = '0; v.ee = 0; v.name = "ls_rst";
      drive_and_check(v);
      held = '0;
      for (int k = 0; k < 30; k++) begin
        if ($urandom_range(0, 2) == 0) begin
          v.rst = 0; v.ce = 0; v.sync = 0; v.din = JUNK; v.ev = 0; v.ed = held; v.name = "ls_stall";
          drive_and_check(v);
        end
        v.rst = 0; v.ce = 1; v.sync = 0; v.din = beat(4 * k); v.name = "ls_beat";
        case (k % 3)
          0:       begin v.ev = 0; v.ed = held; end
          1:       begin v.ev = 1; v.ed = word(12 * (k / 3)); end
          default: begin v.ev = 1; v.ed = word(12 * (k / 3) + 6); end
        endcase
        held = v.ed;
        drive_and_check(v);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
